alu_unary_seq_module: RTL and testbench

//   Sequential, parametrised matrix unary unit for the arithmetic coprocessor ALU.
//   It accepts an NxN matrix of signed DATA_W-bit elements and applies one of four

---
 rtl/alu_unary_seq_module.sv | 140 ++++++++++++++
 tb/tb_alu_unary_seq_module.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unary_seq_module.sv
// ---------------------------------------------------------------------------
// alu_unary_seq_module
//
// Sequential matrix unary unit for the arithmetic coprocessor ALU. An NxN
// matrix of signed DATA_W-bit elements is latched on an accepted start and
// processed LANES elements per clock with one of four element-wise modes:
//   00 wrap negate, 01 saturating negate, 10 saturating abs, 11 pass-through.
// A sticky overflow flag reports whether any element equalled MIN in a
// non-pass mode.
//
// Ports
//   clk       in   1             system clock, rising edge
//   rst_n     in   1             asynchronous active-low reset
//   start     in   1             request an operation, sampled only in IDLE
//   mode      in   2             operation select, sampled with start
//   A_flat    in   N*N*DATA_W    operand matrix, row-major, sampled with start
//   C_flat    out  N*N*DATA_W    result matrix (registered)
//   busy      out  1             high from the accept edge until done falls
//   done      out  1             one-cycle pulse, C_flat complete
//   overflow  out  1             sticky: some element was MIN (modes 00/01/10)
// ---------------------------------------------------------------------------
module alu_unary_seq_module #(
    parameter int DATA_W = 8,
    parameter int N      = 5,
    parameter int LANES  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [N*N*DATA_W-1:0]   A_flat,
    output logic [N*N*DATA_W-1:0]   C_flat,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int ELEMS     = N * N;
    localparam int BEATS     = ELEMS / LANES;
    localparam int BEAT_W    = $clog2(BEATS + 1);
    localparam int LANE_BITS = LANES * DATA_W;

    localparam logic [DATA_W-1:0] MIN_VAL   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_VAL   = ~MIN_VAL;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  state;
    logic [BEAT_W-1:0]       beat;
    logic [N*N*DATA_W-1:0]   a_reg;
    logic [1:0]              mode_reg;
    logic [LANE_BITS-1:0]    lane_res;
    logic                    lane_ovf;

    // Per-element unary operation. Negating MIN wraps back to MIN in mode 00;
    // the saturating modes clamp that single case to MAX instead.
    function automatic logic [DATA_W-1:0] unary_op(input logic [DATA_W-1:0] x,
                                                    input logic [1:0]        m);
        logic [DATA_W-1:0] neg;
        logic              is_min;
        neg    = '0 - x;
        is_min = (x == MIN_VAL);
        case (m)
            2'b00:   return neg;
            2'b01:   return is_min ? MAX_VAL : neg;
            2'b10:   return x[DATA_W-1] ? (is_min ? MAX_VAL : neg) : x;
            default: return x;
        endcase
    endfunction

    // Lane datapath: results and overflow contribution for the slice of the
    // latched operand selected by the current beat. Only meaningful in RUN.
    always_comb begin
        lane_res = '0;
        lane_ovf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_res[l*DATA_W +: DATA_W] =
                unary_op(a_reg[(int'(beat)*LANES + l)*DATA_W +: DATA_W], mode_reg);
            if ((mode_reg != 2'b11) &&
                (a_reg[(int'(beat)*LANES + l)*DATA_W +: DATA_W] == MIN_VAL))
                lane_ovf = 1'b1;
        end
    end

    // Control FSM with registered outputs. IDLE latches operands on start,
    // RUN writes one group of lanes per edge, DONE pulses done for one cycle.
    // busy and done are updated on the same edges as the state so they track
    // it exactly without combinational decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat     <= '0;
            a_reg    <= '0;
            mode_reg <= 2'b00;
            C_flat   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= A_flat;
                        mode_reg <= mode;
                        beat     <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    C_flat[int'(beat)*LANE_BITS +: LANE_BITS] <= lane_res;
                    overflow <= overflow | lane_ovf;
                    beat     <= beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_unary_seq_module.sv
// ---------------------------------------------------------------------------
// tb_alu_unary_seq_module
//
// Self-checking bench for alu_unary_seq_module. A default-parameter instance
// (8-bit, 5x5, 5 lanes) carries most of the directed and random operations;
// a second instance (16-bit, 4x4, 2 lanes) covers the wider configuration.
// Expected results come from an integer-arithmetic reference of the unary
// rules, never from the DUT.
// ---------------------------------------------------------------------------
module tb_alu_unary_seq_module;

    localparam int W1 = 8;
    localparam int E1 = 25;
    localparam int B1 = 5;
    localparam int W2 = 16;
    localparam int E2 = 16;
    localparam int B2 = 8;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [1:0]          mode;
    logic [E1*W1-1:0]    a_flat;
    logic [E1*W1-1:0]    c_flat;
    logic                busy;
    logic                done;
    logic                overflow;

    logic                start2;
    logic [1:0]          mode2;
    logic [E2*W2-1:0]    a_flat2;
    logic [E2*W2-1:0]    c_flat2;
    logic                busy2;
    logic                done2;
    logic                overflow2;

    int compared;
    int mismatched;

    alu_unary_seq_module #(.DATA_W(W1), .N(5), .LANES(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .A_flat   (a_flat),
        .C_flat   (c_flat),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    alu_unary_seq_module #(.DATA_W(W2), .N(4), .LANES(2)) dut_wide (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .mode     (mode2),
        .A_flat   (a_flat2),
        .C_flat   (c_flat2),
        .busy     (busy2),
        .done     (done2),
        .overflow (overflow2)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference for one element: interpret raw bits as signed w-bit, apply the
    // arithmetic rule, and reduce back modulo 2^w.
    function automatic int ref_elem(input int raw, input int m, input int w);
        int half;
        int x;
        int r;
        half = 1 << (w - 1);
        x    = (raw >= half) ? raw - (1 << w) : raw;
        case (m)
            0:       r = -x;
            1:       r = (x == -half) ? half - 1 : -x;
            2:       r = (x < 0) ? ((x == -half) ? half - 1 : -x) : x;
            default: r = x;
        endcase
        return r & ((1 << w) - 1);
    endfunction

    // Whole-matrix reference for the default instance.
    function automatic logic [E1*W1-1:0] ref_matrix(input logic [E1*W1-1:0] a, input int m);
        logic [E1*W1-1:0] c;
        c = '0;
        for (int i = 0; i < E1; i++)
            c[i*W1 +: W1] = W1'(ref_elem(int'(a[i*W1 +: W1]), m, W1));
        return c;
    endfunction

    // Overflow reference: some element is MIN and the mode is not pass-through.
    function automatic logic ref_ovf(input logic [E1*W1-1:0] a, input int m);
        logic f;
        f = 1'b0;
        for (int i = 0; i < E1; i++)
            if (a[i*W1 +: W1] == 8'h80) f = 1'b1;
        return f && (m != 3);
    endfunction

    function automatic logic [E1*W1-1:0] rand_matrix();
        logic [E1*W1-1:0] a;
        for (int i = 0; i < E1; i++) begin
            a[i*W1 +: W1] = W1'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) a[i*W1 +: W1] = 8'h80;
        end
        return a;
    endfunction

    // One comparison: counts it, and on a difference counts and reports it.
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation on the default instance and follows its handshake:
    // done must arrive exactly B1 cycles after accept with busy held high, and
    // both must be low in the following IDLE cycle, where the task returns so
    // the next call can start back-to-back.
    task automatic applyStimulus(input string tag, input logic [1:0] m, input logic [E1*W1-1:0] a);
        int  cyc;
        logic busy_ok;
        mode   = m;
        a_flat = a;
        start  = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_ok = 1'b1;
        cyc     = 0;
        while (cyc < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        checkOutput({tag, " latency"}, 256'(cyc), 256'(B1));
        checkOutput({tag, " busy"}, 256'(busy_ok && busy), 256'(1));
        checkOutput({tag, " result"}, 256'(c_flat), 256'(ref_matrix(a, int'(m))));
        checkOutput({tag, " overflow"}, 256'(overflow), 256'(ref_ovf(a, int'(m))));
        @(posedge clk); #1;
        checkOutput({tag, " idle"}, 256'({busy, done}), 256'(0));
    endtask

    initial begin
        logic [E1*W1-1:0] op_a;
        logic [E1*W1-1:0] op_b;
        logic [E2*W2-1:0] wa;
        logic [E2*W2-1:0] wexp;
        int               cyc;
        logic             saw_done;

        compared   = 0;
        mismatched = 0;
        start      = 1'b0;
        mode       = 2'b00;
        a_flat     = '0;
        start2     = 1'b0;
        mode2      = 2'b00;
        a_flat2    = '0;
        rst_n      = 1'b1;

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset outputs", 256'({busy, done, overflow}), 256'(0));
        checkOutput("reset C_flat", 256'(c_flat), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp i-12 with wrap negate.
        for (int i = 0; i < E1; i++) op_a[i*W1 +: W1] = W1'(i - 12);
        applyStimulus("ramp neg", 2'b00, op_a);
        checkOutput("ramp elem24", 256'(c_flat[24*W1 +: W1]), 256'(8'hF4));

        // MIN / MAX boundaries in the negate modes.
        op_a = '0;
        op_a[0 +: W1] = 8'h80;
        op_a[W1 +: W1] = 8'h7F;
        applyStimulus("min neg-wrap", 2'b00, op_a);
        checkOutput("neg-wrap elem0", 256'(c_flat[0 +: W1]), 256'(8'h80));
        applyStimulus("min neg-sat", 2'b01, op_a);
        checkOutput("neg-sat elem0", 256'(c_flat[0 +: W1]), 256'(8'h7F));

        // Saturating abs, then pass-through of the same operand.
        for (int i = 0; i < E1; i++) op_a[i*W1 +: W1] = 8'h9C;
        op_a[0 +: W1] = 8'h80;
        op_a[W1 +: W1] = 8'hFF;
        op_a[2*W1 +: W1] = 8'h05;
        op_a[3*W1 +: W1] = 8'h00;
        applyStimulus("abs-sat", 2'b10, op_a);
        checkOutput("abs elem4", 256'(c_flat[4*W1 +: W1]), 256'(8'h64));
        applyStimulus("pass", 2'b11, op_a);

        // Start pulsed during RUN with different operands and A_flat changed
        // after accept: the first operation must be unaffected.
        op_a   = rand_matrix();
        op_a[7*W1 +: W1] = 8'h80;
        mode   = 2'b01;
        a_flat = op_a;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        a_flat = ~op_a;
        mode   = 2'b11;
        cyc    = 0;
        while (cyc < 20) begin
            start = (cyc == 1);
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        start = 1'b0;
        checkOutput("ignored start latency", 256'(cyc), 256'(B1));
        checkOutput("ignored start result", 256'(c_flat), 256'(ref_matrix(op_a, 1)));
        checkOutput("ignored start overflow", 256'(overflow), 256'(1));
        @(posedge clk); #1;
        checkOutput("no requeue", 256'(busy), 256'(0));
        op_b = rand_matrix();
        applyStimulus("back-to-back", 2'b10, op_b);

        // Asynchronous reset during beat 2 aborts the operation.
        op_a = rand_matrix();
        op_a[0 +: W1] = 8'h80;
        mode   = 2'b00;
        a_flat = op_a;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort outputs", 256'({busy, done, overflow}), 256'(0));
        checkOutput("abort C_flat", 256'(c_flat), 256'(0));
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort no done", 256'(saw_done), 256'(0));
        applyStimulus("after reset", 2'b01, op_a);

        // Random operations.
        for (int k = 0; k < 12; k++) begin
            op_a = rand_matrix();
            applyStimulus($sformatf("random%0d", k), 2'($urandom_range(0, 3)), op_a);
        end

        // Wide configuration: 16-bit elements, 8 beats.
        for (int i = 0; i < E2; i++) wa[i*W2 +: W2] = W2'($urandom_range(0, 65535));
        wa[0 +: W2] = 16'h8000;
        wexp = '0;
        for (int i = 0; i < E2; i++)
            wexp[i*W2 +: W2] = W2'(ref_elem(int'(wa[i*W2 +: W2]), 1, W2));
        mode2   = 2'b01;
        a_flat2 = wa;
        start2  = 1'b1;
        @(posedge clk); #1;
        start2  = 1'b0;
        cyc     = 0;
        while (cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (done2) break;
        end
        checkOutput("wide latency", 256'(cyc), 256'(B2));
        checkOutput("wide result", 256'(c_flat2), 256'(wexp));
        checkOutput("wide elem0", 256'(c_flat2[0 +: W2]), 256'(16'h7FFF));
        checkOutput("wide overflow", 256'(overflow2), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
